// File: rtl/sdram_pkg.sv
// sdram_pkg: shared state encoding, timing defaults and helpers
// for the SDRAM command sequencer and its wait counter.
package sdram_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int DEF_ROW_BITS = 8;
  localparam int DEF_COL_BITS = 8;
  localparam int DEF_T_RCD    = 2;
  localparam int DEF_T_CAS    = 2;
  localparam int DEF_T_RP     = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACTIVATE  = 3'd1,
    ST_RCD_WAIT  = 3'd2,
    ST_COLUMN    = 3'd3,
    ST_CAS_WAIT  = 3'd4,
    ST_PRECHARGE = 3'd5,
    ST_RP_WAIT   = 3'd6
  } state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int cnt_width(input int tmax);
    return (tmax <= 2) ? 1 : $clog2(tmax);
  endfunction

  // The strobe state itself is one of the T cycles and the
  // zero-count wait cycle is another, hence T-2.
  function automatic int wait_load(input int t);
    return (t >= 2) ? t - 2 : 0;
  endfunction

endpackage

// File: rtl/sdram_wait_counter.sv
// sdram_wait_counter: loadable down-counter with zero flag,
// shared by the tRCD, CAS-latency and tRP wait states.
// Ports:
//   clk_i, reset_i   clock, sync active-high reset
//   load_i           load load_val_i (wins over dec_i)
//   load_val_i       value to load
//   dec_i            decrement, saturating at zero
//   zero_o           count is zero
module sdram_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer: accepts one request and issues a closed-page
// RAS / CAS / precharge sequence honouring tRCD, CL and tRP.
// Ports:
//   clk, reset            clock, sync active-high reset
//   ReqValid/ReqReady     request handshake
//   ReqWrite, ReqAddr     access type and flat {row,col} address
//   RAS, CAS, WE, PRE     registered command strobes
//   RowAddrOut/ColAddrOut registered decoder addresses
//   Done                  access complete (with PRE)
module sdram_cmd_sequencer
  import sdram_pkg::*;
#(
  parameter int ROW_ADDR_DEPTH = DEF_ROW_BITS,
  parameter int COL_ADDR_DEPTH = DEF_COL_BITS,
  parameter int T_RCD          = DEF_T_RCD,
  parameter int T_CAS          = DEF_T_CAS,
  parameter int T_RP           = DEF_T_RP
) (
  input  logic clk,
  input  logic reset,
  input  logic ReqValid,
  output logic ReqReady,
  input  logic ReqWrite,
  input  logic [ROW_ADDR_DEPTH+COL_ADDR_DEPTH-1:0] ReqAddr,
  output logic RAS,
  output logic CAS,
  output logic WE,
  output logic PRE,
  output logic [ROW_ADDR_DEPTH-1:0] RowAddrOut,
  output logic [COL_ADDR_DEPTH-1:0] ColAddrOut,
  output logic Done
);

  localparam int AW = ROW_ADDR_DEPTH + COL_ADDR_DEPTH;
  localparam int CW = cnt_width(max3(T_RCD, T_CAS, T_RP));

  if (T_RCD < 1 || T_CAS < 1 || T_RP < 1) begin : g_bad_timing
    $error("sdram_cmd_sequencer: T_RCD/T_CAS/T_RP must be >= 1");
  end

  state_e state_q;
  state_e state_d;

  logic                      wr_q;
  logic [COL_ADDR_DEPTH-1:0] col_q;

  logic                      ras_q;
  logic                      cas_q;
  logic                      we_q;
  logic                      pre_q;
  logic                      done_q;
  logic [ROW_ADDR_DEPTH-1:0] row_out_q;
  logic [COL_ADDR_DEPTH-1:0] col_out_q;

  logic          enter_act;
  logic          enter_col;
  logic          enter_pre;
  logic          cnt_ld;
  logic          cnt_dec;
  logic [CW-1:0] cnt_ld_val;
  logic          cnt_zero;

  always_comb begin
    state_d   = state_q;
    enter_act = LOW;
    enter_col = LOW;
    enter_pre = LOW;
    cnt_dec   = LOW;
    unique case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          state_d   = ST_ACTIVATE;
          enter_act = HIGH;
        end
      end
      ST_ACTIVATE: begin
        if (T_RCD == 1) begin
          state_d   = ST_COLUMN;
          enter_col = HIGH;
        end else begin
          state_d = ST_RCD_WAIT;
        end
      end
      ST_RCD_WAIT: begin
        cnt_dec = HIGH;
        if (cnt_zero) begin
          state_d   = ST_COLUMN;
          enter_col = HIGH;
        end
      end
      ST_COLUMN: begin
        if (T_CAS == 1) begin
          state_d   = ST_PRECHARGE;
          enter_pre = HIGH;
        end else begin
          state_d = ST_CAS_WAIT;
        end
      end
      ST_CAS_WAIT: begin
        cnt_dec = HIGH;
        if (cnt_zero) begin
          state_d   = ST_PRECHARGE;
          enter_pre = HIGH;
        end
      end
      ST_PRECHARGE: begin
        if (T_RP == 1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RP_WAIT;
        end
      end
      ST_RP_WAIT: begin
        cnt_dec = HIGH;
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Each strobe state preloads the wait that follows it.
  always_comb begin
    cnt_ld     = LOW;
    cnt_ld_val = '0;
    unique case (1'b1)
      (state_q == ST_ACTIVATE): begin
        cnt_ld     = HIGH;
        cnt_ld_val = CW'(wait_load(T_RCD));
      end
      (state_q == ST_COLUMN): begin
        cnt_ld     = HIGH;
        cnt_ld_val = CW'(wait_load(T_CAS));
      end
      (state_q == ST_PRECHARGE): begin
        cnt_ld     = HIGH;
        cnt_ld_val = CW'(wait_load(T_RP));
      end
      default: ;
    endcase
  end

  sdram_wait_counter #(
    .W (CW)
  ) u_wait (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (cnt_ld),
    .load_val_i (cnt_ld_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Outputs are registered on entry to their state so they
  // are valid for exactly the cycle the state is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_q      <= LOW;
      col_q     <= '0;
      ras_q     <= LOW;
      cas_q     <= LOW;
      we_q      <= LOW;
      pre_q     <= LOW;
      done_q    <= LOW;
      row_out_q <= '0;
      col_out_q <= '0;
    end else begin
      state_q <= state_d;
      ras_q   <= enter_act;
      cas_q   <= enter_col;
      we_q    <= enter_col & wr_q;
      pre_q   <= enter_pre;
      done_q  <= enter_pre;
      if (enter_act) begin
        wr_q      <= ReqWrite;
        col_q     <= ReqAddr[COL_ADDR_DEPTH-1:0];
        row_out_q <= ReqAddr[AW-1 -: ROW_ADDR_DEPTH];
      end
      if (enter_col) begin
        col_out_q <= col_q;
      end
    end
  end

  assign ReqReady   = (state_q == ST_IDLE) && !reset;
  assign RAS        = ras_q;
  assign CAS        = cas_q;
  assign WE         = we_q;
  assign PRE        = pre_q;
  assign Done       = done_q;
  assign RowAddrOut = row_out_q;
  assign ColAddrOut = col_out_q;

endmodule

// File: doc/sdram_cmd_sequencer.md
Name: sdram_cmd_sequencer

Overview:
- Upstream neighbour of the row/column decoder registers in the SDRAM model.
- Accepts one read/write request over a valid/ready handshake and splits the flat address into row and column fields.
- Issues a closed-page sequence: RAS (activate), CAS (read/write), then precharge, honouring tRCD, CAS latency and tRP in clock cycles.
- Its RAS/RowAddrOut and CAS/ColAddrOut feed the row and column decoders directly.

Parameters:
- ROW_ADDR_DEPTH, 8, row address bits.
- COL_ADDR_DEPTH, 8, column address bits.
- T_RCD, 2, cycles from the RAS cycle to the CAS cycle (>=1).
- T_CAS, 2, cycles from the CAS cycle to the Done cycle (>=1).
- T_RP, 2, cycles from the precharge cycle back to ready (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  sequencer can accept a request.
- ReqWrite  input  1  1 = write, 0 = read; sampled on accept.
- ReqAddr  input  ROW_ADDR_DEPTH+COL_ADDR_DEPTH  flat address; row = upper ROW_ADDR_DEPTH bits, column = lower COL_ADDR_DEPTH bits.
- RAS  output  1  row address strobe, active-high, 1-cycle pulse.
- CAS  output  1  column address strobe, active-high, 1-cycle pulse.
- WE  output  1  write enable, valid only while CAS=1; 0 otherwise.
- PRE  output  1  precharge strobe, 1-cycle pulse.
- RowAddrOut  output  ROW_ADDR_DEPTH  row address to the row decoder.
- ColAddrOut  output  COL_ADDR_DEPTH  column address to the column decoder.
- Done  output  1  1-cycle pulse when the access completes.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); it is sampled only on the rising edge.
- Reset values: RAS=CAS=WE=PRE=Done=0, RowAddrOut=0, ColAddrOut=0, state IDLE, wait counter 0.
- ReqReady=1 only in IDLE with reset=0. It is a combinational decode of the state register.
- FSM states and transitions:
  - IDLE: on ReqValid&ReqReady at a rising edge, latch ReqWrite and both address fields, then go to ACTIVATE.
  - ACTIVATE: RAS=1 and RowAddrOut=row. If T_RCD=1 go to COLUMN; otherwise load counter T_RCD-2 and go to RCD_WAIT.
  - RCD_WAIT: all strobes 0; decrement; at 0 go to COLUMN.
  - COLUMN: CAS=1, ColAddrOut=col, WE=latched write bit. If T_CAS=1 go to PRECHARGE; otherwise go to CAS_WAIT with counter T_CAS-2.
  - CAS_WAIT: all strobes 0; decrement; at 0 go to PRECHARGE.
  - PRECHARGE: PRE=1 and Done=1 in the same cycle. If T_RP=1 go to IDLE; otherwise go to RP_WAIT with counter T_RP-2.
  - RP_WAIT: decrement; at 0 go to IDLE.
- Timing from the accept edge E:
  - RAS in cycle E+1.
  - CAS in cycle E+1+T_RCD.
  - PRE/Done in cycle E+1+T_RCD+T_CAS.
  - ReqReady=1 in cycle E+1+T_RCD+T_CAS+T_RP.
  - Defaults give RAS at 1, CAS at 3, Done at 5, ready at 7.
- Strobes and WE are registered outputs with no combinational path from inputs. The address outputs are registered.
- RowAddrOut and ColAddrOut hold their last driven value between accesses. They change only in ACTIVATE and COLUMN respectively.
- ReqValid while busy is ignored: no accept, no side effects. The requester must hold the request until accepted.
- Back-to-back requests: ReqValid held high is accepted on the first IDLE cycle, so there is no idle bubble beyond tRP.
- Reset mid-operation: abort immediately; the next cycle is IDLE with all outputs at reset values and no Done or PRE for the aborted access. ReqReady=1 in the first cycle after reset deasserts.
- Simultaneous reset and ReqValid: reset wins; the request is not accepted.
- Counter width: $clog2 of the maximum of T_RCD, T_CAS, T_RP, minimum 1 bit. Elaboration rejects any T_* < 1.

Decomposition:
- Shared package (sdram_pkg): state encoding localparams (IDLE … RP_WAIT, 3 bits), default timing constants, and HIGH/LOW defines.
- One natural sub-module: sdram_wait_counter (load value, load enable, decrement, zero flag), reused for the three wait states. The FSM and output registers stay in the top module.

Test Plan:
- Reset then idle: assert reset 2 cycles -> all outputs 0, ReqReady=0 during reset and 1 on the first cycle after.
- Single read with defaults, ReqAddr=16'hA53C, ReqWrite=0, accepted at edge 0 -> RAS at cycle 1 with RowAddrOut=8'hA5; CAS at 3 with ColAddrOut=8'h3C and WE=0; PRE=Done=1 at 5; ReqReady=1 at 7.
- Single write with ReqAddr=16'h0102, ReqWrite=1 -> WE=1 only in the CAS cycle; RowAddrOut=8'h01, ColAddrOut=8'h02.
- Back-to-back requests with ReqValid held high and a second address 16'hFFFF -> second accept at cycle 7, second RAS at cycle 8 with RowAddrOut=8'hFF; the first access's outputs are unaffected.
- Reset asserted in the cycle after CAS -> no Done or PRE; IDLE and ReqReady=1 the cycle after reset drops; address outputs 0.
- Parameter sweep T_RCD=T_CAS=T_RP=1 -> RAS at 1, CAS at 2, Done at 3, ready at 4; plus T_RCD=4, which gives CAS at cycle 5.
